// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the parametrised register file.
// Used by regfile_param and regfile_clear_fsm.
package regfile_pkg;

    // Bulk-clear engine states
    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;

    // Widest word the merge helper handles; callers
    // zero-extend into it and truncate the result.
    localparam int MERGE_W  = 1024;
    localparam int MERGE_BE = MERGE_W / 8;

    // Byte-wise merge: bytes with be set come from
    // new_v, the rest keep old_v.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]  old_v,
        input logic [MERGE_W-1:0]  new_v,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] r;
        r = old_v;
        for (int i = 0; i < MERGE_BE; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential bulk-clear engine: sweeps one entry per cycle,
// reports busy during the sweep and pulses done at the end.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_stb,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t    state;
    logic [AW-1:0] ptr;

    // Clear FSM with registered busy/done flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLR_IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            unique case (state)
                CLR_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLR_SWEEP;
                        ptr      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    if (ptr == LAST) begin
                        state    <= CLR_DONE;
                        ptr      <= '0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                CLR_DONE: begin
                    state    <= CLR_IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= CLR_IDLE;
                    ptr      <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // The array clears the pointed entry on every sweep edge
    assign clr_stb  = clr_busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with byte enables,
// optional zero entry and bulk clear. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter bit  ZERO_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH),
    localparam int NBE      = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NBE-1:0]   wbe,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             clr_stb;
    logic [AW-1:0]    clr_addr;
    logic             wr_ok;
    logic [WIDTH-1:0] old_w;
    logic [WIDTH-1:0] wr_merged;

    // Address lies inside the populated part of the array
    function automatic logic in_rng(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    // Address hits the hard-wired zero entry
    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_stb  (clr_stb),
        .clr_addr (clr_addr)
    );

    // Write acceptance and the merged word shared by write and bypass
    always_comb begin
        wr_ok = we && !clr_busy && in_rng(waddr) && !is_zero(waddr);
        old_w = '0;
        if (in_rng(waddr)) begin
            old_w = mem[waddr];
        end
        wr_merged = WIDTH'(byte_merge(MERGE_W'(old_w),
                                      MERGE_W'(wdata),
                                      MERGE_BE'(wbe)));
    end

    // Storage: reset, sweep clear, or byte-enabled write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_stb) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wr_merged;
        end
    end

    // Read port A
    always_comb begin
        rdata_a = '0;
        if (in_rng(raddr_a) && !is_zero(raddr_a)) begin
            rdata_a = mem[raddr_a];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (raddr_a == waddr)) begin
            rdata_a = wr_merged;
        end
`endif
    end

    // Read port B
    always_comb begin
        rdata_b = '0;
        if (in_rng(raddr_b) && !is_zero(raddr_b)) begin
            rdata_b = mem[raddr_b];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (raddr_b == waddr)) begin
            rdata_b = wr_merged;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: two instances (16x32 plain,
// 12x32 with zero entry) share stimulus and are checked against a model.
module tb_regfile_param;

    localparam int AW = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          we = 1'b0;
    logic          clr_req = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr_a = '0;
    logic [AW-1:0] raddr_b = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wbe = '0;

    logic [31:0] ra0, rb0, ra1, rb1;
    logic        busy0, busy1, done0, done1;

    regfile_param #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra0), .rdata_b(rb0), .clr_req(clr_req),
        .clr_busy(busy0), .clr_done(done0)
    );

    regfile_param #(.WIDTH(32), .DEPTH(12), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(ra1), .rdata_b(rb1), .clr_req(clr_req),
        .clr_busy(busy1), .clr_done(done1)
    );

    always #5 clk = ~clk;

    // Reference model: per instance a word array plus clear phase
    int          dep [2] = '{16, 12};
    bit          zr  [2] = '{1'b0, 1'b1};
    logic [31:0] m   [2][16];
    int          phase [2];
    int          pos   [2];

    typedef struct packed {
        logic [1:0][31:0] ra;
        logic [1:0][31:0] rb;
        logic [1:0]       busy;
        logic [1:0]       done;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic bit accepted(input int k);
        return we && (phase[k] != 1) && (int'(waddr) < dep[k])
               && !(zr[k] && waddr == 0);
    endfunction

    function automatic logic [31:0] peek(input int k, input int a);
        logic [31:0] r;
        r = 32'h0;
        if (a < dep[k] && !(zr[k] && a == 0)) r = m[k][a];
        if (BYP && accepted(k) && a == int'(waddr))
            r = merge(m[k][a], wdata, wbe);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m[k][i] = 32'h0;
            phase[k] = 0;
            pos[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        if (accepted(k)) m[k][waddr] = merge(m[k][waddr], wdata, wbe);
        case (phase[k])
            0: if (clr_req) begin phase[k] = 1; pos[k] = 0; end
            1: begin
                m[k][pos[k]] = 32'h0;
                pos[k]++;
                if (pos[k] == dep[k]) phase[k] = 2;
            end
            default: phase[k] = 0;
        endcase
    endtask

    // One cycle of stimulus; pushes the expected response
    task automatic step(input bit rn, input bit we_, input int wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int ra, input int rb, input bit cr);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rn;
        we = we_;
        waddr = AW'(wa);
        wdata = wd;
        wbe = be;
        raddr_a = AW'(ra);
        raddr_b = AW'(rb);
        clr_req = cr;
        if (!rn) model_reset();
        e.cyc = cyc;
        for (int k = 0; k < 2; k++) begin
            e.ra[k] = peek(k, int'(raddr_a));
            e.rb[k] = peek(k, int'(raddr_b));
            e.busy[k] = (phase[k] == 1);
            e.done[k] = (phase[k] == 2);
        end
        q.push_back(e);
        if (rn) for (int k = 0; k < 2; k++) model_edge(k);
        cyc++;
    endtask

    task automatic idle(input int ra, input int rb);
        step(1, 0, 0, 32'h0, 4'h0, ra, rb, 0);
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++)
            step(1, 1, i, 32'($urandom) | 32'h1, 4'hF, i, 15 - i, 0);
    endtask

    task automatic rnd_steps(input int n, input int clr_odds);
        for (int i = 0; i < n; i++)
            step(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 32'($urandom), 4'($urandom), $urandom_range(0, 15),
                 $urandom_range(0, 15),
                 clr_odds > 0 && $urandom_range(0, clr_odds - 1) == 0);
    endtask

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("a.rdata_a", e.cyc, ra0, e.ra[0]);
                chk("a.rdata_b", e.cyc, rb0, e.rb[0]);
                chk("a.clr_busy", e.cyc, 32'(busy0), 32'(e.busy[0]));
                chk("a.clr_done", e.cyc, 32'(done0), 32'(e.done[0]));
                chk("b.rdata_a", e.cyc, ra1, e.ra[1]);
                chk("b.rdata_b", e.cyc, rb1, e.rb[1]);
                chk("b.clr_busy", e.cyc, 32'(busy1), 32'(e.busy[1]));
                chk("b.clr_done", e.cyc, 32'(done1), 32'(e.done[1]));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) step(0, 0, 0, 32'h0, 4'h0, 5, 9, 0);
        idle(5, 9);

        step(1, 1, 5, 32'hDEADBEEF, 4'hF, 5, 5, 0);
        idle(5, 4);
        for (int i = 0; i < 16; i++) idle(i, 15 - i);

        step(1, 1, 3, 32'h11223344, 4'hF, 3, 3, 0);
        step(1, 1, 3, 32'hAABBCCDD, 4'b0101, 3, 3, 0);
        idle(3, 3);

        step(1, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        idle(0, 0);

        step(1, 1, 13, 32'hCAFEF00D, 4'hF, 13, 13, 0);
        idle(13, 12);
        for (int i = 0; i < 16; i++) idle(i, i);

        step(1, 1, 7, 32'h12345678, 4'hF, 7, 7, 0);
        idle(7, 7);
        step(1, 1, 7, 32'h0, 4'h0, 7, 7, 0);

        fill();
        step(1, 0, 0, 32'h0, 4'h0, 0, 1, 1);
        for (int i = 0; i < 20; i++)
            step(1, 1, $urandom_range(0, 15), 32'($urandom), 4'hF,
                 $urandom_range(0, 15), $urandom_range(0, 15), 0);
        for (int i = 0; i < 16; i++) idle(i, 15 - i);

        fill();
        step(1, 1, 2, 32'h55AA55AA, 4'hF, 2, 3, 1);
        for (int i = 0; i < 6; i++) idle(i, 15 - i);
        step(0, 0, 0, 32'h0, 4'h0, 8, 9, 0);
        step(0, 0, 0, 32'h0, 4'h0, 10, 11, 0);
        idle(10, 11);
        fill();
        step(1, 0, 0, 32'h0, 4'h0, 4, 5, 1);
        for (int i = 0; i < 20; i++) idle(i % 16, 15 - (i % 16));

        step(1, 1, 9, 32'h9999AAAA, 4'hF, 9, 9, 1);
        for (int i = 0; i < 40; i++)
            step(1, 0, 0, 32'h0, 4'h0, i % 16, 9, 1);

        rnd_steps(300, 0);
        rnd_steps(300, 25);

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", cyc, 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file: the next generation of the team's fixed 16 × 32-bit register file with its 4-to-16 load decoder and 16:1 read mux. It adds configurable width and depth, byte-enabled writes, an optional hard-wired zero entry, optional write-to-read bypass, and a sequential bulk-clear engine with a busy/done handshake. It sits in the datapath between the instruction decoder (read/write addresses) and the ALU and writeback stages.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8
- DEPTH, 16, number of entries; 2..256
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes
- AW, $clog2(DEPTH), address width; derived, not overridden
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- wbe  in  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
- raddr_a, raddr_b  in  AW  read addresses
- rdata_a, rdata_b  out  WIDTH  read data, combinational from address
- clr_req  in  1  bulk-clear request, sampled on clk
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  single-cycle pulse at sweep completion

## Operation
- Reset (reset_n low, asynchronous): all entries 0, clr_busy 0, clr_done 0, FSM IDLE, sweep pointer 0.
- Write: on a rising edge with we=1, clr_busy=0 and waddr<DEPTH, each byte of entry[waddr] with its wbe bit set takes the matching wdata byte; other bytes hold. we=1 with wbe=0 is a no-op.
- Ignored writes: waddr≥DEPTH; waddr=0 when ZERO_REG=1; any write while clr_busy=1. An ignored write leaves all state unchanged.
- Read: rdata_x = entry[raddr_x]; raddr_x≥DEPTH returns 0; raddr_x=0 with ZERO_REG=1 returns 0. Both ports are independent and may use the same address.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 → SWEEP, pointer ← 0.
  - SWEEP: each edge, entry[pointer] ← 0 and pointer increments; on the edge that clears DEPTH-1 → DONE.
  - DONE: one cycle, then → IDLE.
- clr_busy=1 exactly in SWEEP. clr_done=1 exactly in DONE.
- clr_req is ignored outside IDLE. A request held high re-triggers a sweep from the IDLE cycle after DONE.
- we and clr_req on the same IDLE edge: the write is performed, and the subsequent sweep clears it.

## Timing
- Write latency: data is visible on a read port in the cycle after the write edge (zero cycles with bypass; see Configuration).
- Clear: clr_req sampled at edge E0 → clr_busy high after E0; entries 0..DEPTH-1 clear at edges E1..EDEPTH; after EDEPTH, clr_busy=0 and clr_done=1; after EDEPTH+1, clr_done=0. Total DEPTH+1 cycles from request to done.
- Reads during a sweep return live contents: entries already cleared read 0, the rest read their old values.
- Reset asserted mid-sweep: immediate return to IDLE with all entries 0; no clr_done pulse.

## Configuration
- REGFILE_BYPASS_EN defined: when a write is accepted (we=1, not ignored) and raddr_x==waddr, rdata_x shows the merged value in the same cycle: wdata bytes where wbe is set, stored bytes elsewhere.
- REGFILE_BYPASS_EN undefined: rdata_x shows the stored (pre-write) value until the edge.
- Ignored writes are never bypassed.

## Structure
- Package regfile_pkg holds:
  - the clear-FSM state enum (IDLE, SWEEP, DONE)
  - default WIDTH/DEPTH constants
  - a byte-merge function (old, new, be) shared by the write path and the bypass path.
- One sub-module, regfile_clear_fsm: owns the state, the pointer, clr_busy and clr_done, and outputs a clear-strobe plus clear-address to the storage array.
- Storage array, write decode and read muxes stay in regfile_param.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5 with wbe=4'hF → rdata_a(raddr=5)=0xDEADBEEF the next cycle; all other addresses read 0.
- Entry 3 holds 0x11223344; write 0xAABBCCDD with wbe=4'b0101 → entry 3 = 0x11BB33DD.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 → reads 0. DEPTH=12: raddr=13 reads 0, and a write to addr 13 alters no entry.
- Bypass: write 0x12345678 to addr 7 with raddr_a=raddr_b=7 → both ports show 0x12345678 in the same cycle with REGFILE_BYPASS_EN defined; old value in that cycle without it.
- Clear with DEPTH=16 and all entries nonzero: pulse clr_req → clr_busy high 16 cycles, clr_done one pulse, all entries read 0. A write issued mid-sweep is dropped.
- Assert reset_n low at sweep cycle 6 → clr_busy=0 immediately, all entries 0, no clr_done; a new clr_req afterwards completes normally.
